// File: rtl/comar_mask_prng_if.sv
// Handshake and data bundle between the COMAR fresh-mask source and its user.
// The master drives seed/enable/hold controls; the slave returns masks.
interface comar_mask_prng_if #(
    parameter int NUM_R = 6
) ();
    logic [31:0]      seed_in;
    logic             seed_load;
    logic             seed_ack;
    logic             en;
    logic             common_hold;
    logic [NUM_R-1:0] r_out;
    logic             common_out;
    logic             r_valid;

    modport master (
        output seed_in,
        output seed_load,
        output en,
        output common_hold,
        input  seed_ack,
        input  r_out,
        input  common_out,
        input  r_valid
    );

    modport slave (
        input  seed_in,
        input  seed_load,
        input  en,
        input  common_hold,
        output seed_ack,
        output r_out,
        output common_out,
        output r_valid
    );
endinterface

// File: rtl/comar_mask_prng.sv
// Fresh-mask source for COMAR gadgets: 32-bit Fibonacci LFSR advanced
// NUM_R+1 bits per enabled cycle, with reseed handshake and warm-up.
module comar_mask_prng #(
    parameter int          NUM_R        = 6,
    parameter int          WARMUP       = 16,
    parameter logic [31:0] DEFAULT_SEED = 32'hACE1_5EED
) (
    input  logic                clk,
    input  logic                rst,
    comar_mask_prng_if.slave    bus
);
    localparam int STEP = NUM_R + 1;
    localparam int CW   = $clog2(WARMUP + 1);
    localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);

    typedef enum logic {
        WARM,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [CW-1:0]    warm_cnt_q, warm_cnt_d;
    logic [NUM_R-1:0] r_q, r_d;
    logic             common_q, common_d;
    logic             valid_q, valid_d;
    logic             ack_q, ack_d;

    logic [31:0]      adv_lfsr;
    logic [STEP-1:0]  adv_bits;

    // Unrolled multi-step advance; bit i is the MSB seen before step i.
    always_comb begin
        logic [31:0] s;
        s        = lfsr_q;
        adv_bits = '0;
        for (int i = 0; i < STEP; i++) begin
            adv_bits[i] = s[31];
            s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        end
        adv_lfsr = s;
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        warm_cnt_d = warm_cnt_q;
        r_d        = r_q;
        common_d   = common_q;
        valid_d    = valid_q;
        ack_d      = 1'b0;
        if (bus.seed_load) begin
            lfsr_d     = (bus.seed_in == 32'd0) ? DEFAULT_SEED
                                                : bus.seed_in;
            warm_cnt_d = '0;
            state_d    = WARM;
            valid_d    = 1'b0;
            ack_d      = 1'b1;
            r_d        = '0;
            common_d   = 1'b0;
        end else if (bus.en) begin
            lfsr_d = adv_lfsr;
            r_d    = adv_bits[NUM_R-1:0];
            if (!bus.common_hold) begin
                common_d = adv_bits[NUM_R];
            end
            unique case (state_q)
                WARM: begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                    end
                end
                RUN: begin
                    valid_d = 1'b1;
                end
                default: begin
                    state_d = WARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WARM;
            lfsr_q     <= DEFAULT_SEED;
            warm_cnt_q <= '0;
            r_q        <= '0;
            common_q   <= 1'b0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            warm_cnt_q <= warm_cnt_d;
            r_q        <= r_d;
            common_q   <= common_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.r_out      = r_q;
    assign bus.common_out = common_q;
    assign bus.r_valid    = valid_q;
    assign bus.seed_ack   = ack_q;
endmodule

// File: tb/tb_comar_mask_prng.sv
// Bench for comar_mask_prng: bit-serial LFSR stream model, directed
// sequences, a vector table and a randomized run.
module tb_comar_mask_prng;
    localparam int          NUM_R  = 6;
    localparam int          WARMUP = 16;
    localparam logic [31:0] DSEED  = 32'hACE1_5EED;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    comar_mask_prng_if #(.NUM_R(NUM_R)) bus ();

    comar_mask_prng #(
        .NUM_R(NUM_R),
        .WARMUP(WARMUP),
        .DEFAULT_SEED(DSEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the mask stream is just consecutive bits of a
    // bit-serial LFSR, NUM_R+1 consumed per advance.
    logic [31:0]      m_s;
    int               m_adv;
    bit               m_valid, m_ack, m_c;
    logic [NUM_R-1:0] m_r;

    function automatic bit next_bit();
        bit b;
        b   = m_s[31];
        m_s = {m_s[30:0], m_s[31] ^ m_s[21] ^ m_s[1] ^ m_s[0]};
        return b;
    endfunction

    function automatic bit stream_bit(logic [31:0] seed, int idx);
        logic [31:0] s;
        bit b;
        s = seed;
        b = 1'b0;
        for (int i = 0; i <= idx; i++) begin
            b = s[31];
            s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        end
        return b;
    endfunction

    task automatic model_reset();
        m_s = DSEED; m_adv = 0; m_valid = 0;
        m_ack = 0; m_c = 0; m_r = '0;
    endtask

    task automatic model_step(bit ld, logic [31:0] sd, bit en, bit hold);
        bit b;
        m_ack = ld;
        if (ld) begin
            m_s = (sd == 0) ? DSEED : sd;
            m_adv = 0; m_valid = 0; m_r = '0; m_c = 0;
        end else if (en) begin
            for (int i = 0; i < NUM_R; i++) m_r[i] = next_bit();
            b = next_bit();
            if (!hold) m_c = b;
            m_adv++;
            if (m_adv >= WARMUP) m_valid = 1;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".r_out"}, 32'(bus.r_out), 32'(m_r));
        chk({tag, ".common"}, 32'(bus.common_out), 32'(m_c));
        chk({tag, ".valid"}, 32'(bus.r_valid), 32'(m_valid));
        chk({tag, ".ack"}, 32'(bus.seed_ack), 32'(m_ack));
    endtask

    task automatic cycle(bit ld, logic [31:0] sd, bit en, bit hold, string tag);
        bus.seed_load = ld; bus.seed_in = sd;
        bus.en = en; bus.common_hold = hold;
        @(posedge clk);
        model_step(ld, sd, en, hold);
        #1;
        chk_all(tag);
    endtask

    typedef struct {
        bit          ld;
        logic [31:0] sd;
        bit          en;
        bit          hold;
        bit          exp_ack;
        bit          exp_valid;
    } vec_t;

    vec_t             tbl[8];
    logic [NUM_R-1:0] rec_r[WARMUP];
    bit               rec_c[WARMUP];
    logic [NUM_R-1:0] exp_r;
    bit               held_c;

    initial begin
        tbl[0] = '{1, 32'h1234_5678, 0, 0, 1, 0};
        tbl[1] = '{1, 32'hDEAD_BEEF, 1, 0, 1, 0};
        tbl[2] = '{0, 32'h0,         0, 0, 0, 0};
        tbl[3] = '{0, 32'h0,         1, 0, 0, 0};
        tbl[4] = '{0, 32'h0,         1, 1, 0, 0};
        tbl[5] = '{0, 32'h0,         0, 0, 0, 0};
        tbl[6] = '{1, 32'h0,         1, 1, 1, 0};
        tbl[7] = '{0, 32'h0,         1, 0, 0, 0};

        rst = 1'b1;
        bus.seed_load = 0; bus.seed_in = '0;
        bus.en = 0; bus.common_hold = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b0;

        // Warm-up from reset; record the default-seed stream.
        for (int i = 0; i < WARMUP; i++) begin
            cycle(0, 0, 1, 0, "warm1");
            rec_r[i] = bus.r_out;
            rec_c[i] = bus.common_out;
        end
        chk("valid_after_16", 32'(bus.r_valid), 32'd1);

        // Common share frozen while r keeps moving.
        held_c = bus.common_out;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 1, 1, "hold");
            chk("hold_const", 32'(bus.common_out), 32'(held_c));
        end
        cycle(0, 0, 1, 0, "hold_release");

        // Enable gaps must not skip stream bits.
        cycle(0, 0, 1, 0, "gap");
        cycle(0, 0, 0, 0, "gap");
        cycle(0, 0, 0, 0, "gap");
        cycle(0, 0, 1, 0, "gap");

        // Reseed to 1 with en also high: load wins.
        cycle(1, 32'h1, 1, 0, "seed1");
        for (int i = 0; i < WARMUP; i++) cycle(0, 0, 1, 0, "warm_s1");
        cycle(0, 0, 1, 0, "seed1_next");
        for (int i = 0; i < NUM_R; i++) exp_r[i] = stream_bit(32'h1, 112 + i);
        chk("seed1_bits112", 32'(bus.r_out), 32'(exp_r));

        // Zero seed replays the post-reset stream.
        cycle(1, 32'h0, 0, 0, "seed0");
        for (int i = 0; i < WARMUP; i++) begin
            cycle(0, 0, 1, 0, "warm_s0");
            chk("seed0_r_replay", 32'(bus.r_out), 32'(rec_r[i]));
            chk("seed0_c_replay", 32'(bus.common_out), 32'(rec_c[i]));
        end

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].ld, tbl[i].sd, tbl[i].en, tbl[i].hold, "tbl");
            chk("tbl_ack", 32'(bus.seed_ack), 32'(tbl[i].exp_ack));
            chk("tbl_valid", 32'(bus.r_valid), 32'(tbl[i].exp_valid));
        end

        // Async reset mid warm-up, with a seed request pending.
        cycle(1, 32'hCAFE_F00D, 0, 0, "pre_rst");
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, "pre_rst_warm");
        bus.seed_load = 1; bus.seed_in = 32'h5555_AAAA; bus.en = 1;
        #1 rst = 1'b1;
        #1;
        chk("async_r", 32'(bus.r_out), 32'd0);
        chk("async_c", 32'(bus.common_out), 32'd0);
        chk("async_valid", 32'(bus.r_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("async_ack", 32'(bus.seed_ack), 32'd0);
        bus.seed_load = 0;
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < WARMUP; i++) cycle(0, 0, 1, 0, "warm_rst");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit ld, en, hold;
            logic [31:0] sd;
            ld   = ($urandom_range(0, 19) == 0);
            sd   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            en   = ($urandom_range(0, 3) != 0);
            hold = ($urandom_range(0, 3) == 0);
            cycle(ld, sd, en, hold, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
